// File: rtl/tff_updown_counter.sv
// tff_updown_counter: up/down modulo counter built from T-type toggle cells.
// Each bit updates as q[i] <= q[i] ^ t_vec[i]. The toggle vector comes from the
// count direction and wrap detection. Load has priority over counting.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (q=0, wrap=0)
//   en        count enable, one step per clk
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous parallel load strobe (clamped to MODULUS-1)
//   load_val  value for load
//   q         current count (registered)
//   t_vec     toggle vector applied at the next edge (combinational)
//   wrap      registered 1-cycle pulse: a wrap occurred at the last edge
module tff_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             wrap
);

    // One extra bit so MODULUS == 2**WIDTH is representable in range checks.
    localparam int unsigned         EXT_W   = WIDTH + 1;
    localparam logic [WIDTH-1:0]    MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [EXT_W-1:0]    MOD_EXT = EXT_W'(MODULUS);

    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] load_clamped;
    logic             chain_one;
    logic             chain_zero;
    logic             out_of_range;
    logic             at_max;
    logic             at_zero;
    logic             wrap_c;

    assign out_of_range = ({1'b0, q} >= MOD_EXT);
    assign at_max       = (q == MAX_VAL);
    assign at_zero      = (q == '0);
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

    // Ripple toggle chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        t_up       = '0;
        t_dn       = '0;
        chain_one  = 1'b1;
        chain_zero = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            t_up[i]    = chain_one;
            t_dn[i]    = chain_zero;
            chain_one  = chain_one & q[i];
            chain_zero = chain_zero & ~q[i];
        end
    end

    // Toggle selection: wrap cases pick a vector that lands exactly on 0 or MAX_VAL.
    always_comb begin
        t_vec  = '0;
        wrap_c = 1'b0;
        if (!load && en) begin
            if (out_of_range) begin
                t_vec  = q;
                wrap_c = 1'b1;
            end else if (up) begin
                if (at_max) begin
                    t_vec  = q;
                    wrap_c = 1'b1;
                end else begin
                    t_vec = t_up;
                end
            end else begin
                if (at_zero) begin
                    t_vec  = MAX_VAL;
                    wrap_c = 1'b1;
                end else begin
                    t_vec = t_dn;
                end
            end
        end
    end

    // Toggle-cell register bank plus wrap strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_clamped;
            wrap <= 1'b0;
        end else begin
            q    <= q ^ t_vec;
            wrap <= wrap_c;
        end
    end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Testbench for tff_updown_counter: two instances (MODULUS 10 and 16) share
// stimulus; a behavioural model pushes expected q/wrap into per-instance
// queues when stimulus is driven, popped and compared after the edge.
module tb_tff_updown_counter;

    typedef struct packed {
        logic [3:0] q;
        logic       w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q10, t10, q16, t16;
    logic       w10, w16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] mq10, mq16;
    exp_t       sb10[$];
    exp_t       sb16[$];

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q10), .t_vec(t10), .wrap(w10)
    );

    tff_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q16), .t_vec(t16), .wrap(w16)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural next-state model in plain modulo arithmetic.
    task automatic model_next(input int m, input logic [3:0] cq, input logic e,
                              input logic u, input logic l, input logic [3:0] lv,
                              output logic [3:0] nq, output logic nw, output logic [3:0] nt);
        int v;
        v  = int'(cq);
        nw = 1'b0;
        if (l) begin
            nq = (int'(lv) >= m) ? 4'(m - 1) : lv;
            nt = 4'd0;
            return;
        end
        if (!e) begin
            nq = cq;
        end else if (v >= m) begin
            nq = 4'd0;
            nw = 1'b1;
        end else if (u) begin
            if (v == m - 1) begin
                nq = 4'd0;
                nw = 1'b1;
            end else begin
                nq = 4'(v + 1);
            end
        end else begin
            if (v == 0) begin
                nq = 4'(m - 1);
                nw = 1'b1;
            end else begin
                nq = 4'(v - 1);
            end
        end
        nt = cq ^ nq;
    endtask

    task automatic compare_out();
        exp_t x;
        if (sb10.size() == 0) begin
            check_val("sb10_empty", 8'd1, 8'd0);
        end else begin
            x = sb10.pop_front();
            check_val("q10", {4'd0, q10}, {4'd0, x.q});
            check_val("wrap10", {7'd0, w10}, {7'd0, x.w});
        end
        if (sb16.size() == 0) begin
            check_val("sb16_empty", 8'd1, 8'd0);
        end else begin
            x = sb16.pop_front();
            check_val("q16", {4'd0, q16}, {4'd0, x.q});
            check_val("wrap16", {7'd0, w16}, {7'd0, x.w});
        end
    endtask

    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lv);
        logic [3:0] nq10, nt10, nq16, nt16;
        logic       nw10, nw16;
        exp_t       x;
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv;
        #1;
        model_next(10, mq10, e, u, l, lv, nq10, nw10, nt10);
        model_next(16, mq16, e, u, l, lv, nq16, nw16, nt16);
        check_val("t_vec10", {4'd0, t10}, {4'd0, nt10});
        check_val("t_vec16", {4'd0, t16}, {4'd0, nt16});
        x.q = nq10; x.w = nw10; sb10.push_back(x);
        x.q = nq16; x.w = nw16; sb16.push_back(x);
        mq10 = nq10;
        mq16 = nq16;
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Drop reset a couple of ns after an edge, check immediately, release at negedge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_val({tag, "_q10"}, {4'd0, q10}, 8'd0);
        check_val({tag, "_w10"}, {7'd0, w10}, 8'd0);
        check_val({tag, "_q16"}, {4'd0, q16}, 8'd0);
        check_val({tag, "_w16"}, {7'd0, w16}, 8'd0);
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        rst_n = 1'b1;
        mq10 = 4'd0;
        mq16 = 4'd0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
        mq10 = 4'd0; mq16 = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_q10", {4'd0, q10}, 8'd0);
        check_val("rst_w10", {7'd0, w10}, 8'd0);
        check_val("rst_q16", {4'd0, q16}, 8'd0);
        check_val("rst_t10", {4'd0, t10}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Count up 12 clocks from 0: wraps at 9 -> 0 for modulus 10.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 4'd0);

        // Reset while wrap is high discards count and wrap.
        step(1'b0, 1'b0, 1'b1, 4'd9);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check_val("pre_rst_wrap10", {7'd0, w10}, 8'd1);
        mid_reset("rst_wrap");

        // Reset mid-count at q=5, then hold at 0 while en is low.
        step(1'b0, 1'b0, 1'b1, 4'd5);
        mid_reset("rst_mid");
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);

        // Count down from 1: 0, wrap to MAX, then MAX-1.
        step(1'b0, 1'b0, 1'b1, 4'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0);

        // Over-range load clamps, load beats en, then an up step wraps.
        step(1'b1, 1'b1, 1'b1, 4'd13);
        step(1'b1, 1'b1, 1'b0, 4'd0);

        // Enable and direction changing every cycle from 3.
        step(1'b0, 1'b0, 1'b1, 4'd3);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);

        // Full-range wrap for modulus 16 from 14.
        step(1'b0, 1'b0, 1'b1, 4'd14);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);

        // Back-to-back down wraps on modulus 16 cannot happen, so run a random mix.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
        end

        if (sb10.size() != 0 || sb16.size() != 0) check_val("sb_leftover", 8'd1, 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
